display_scan_mux: RTL and testbench

- Time-multiplexed scan driver for a common-anode multi-digit 7-segment display.
- Sits directly upstream of the hex-to-7-segment decoder. Each refresh slot it presents one 4-bit nibble to the decoder and drives the matching active-low anode and decimal point.
- Captures a coherent snapshot of the display value once per scan frame, so digits never tear mid-frame.
- Optionally blanks leading zeros.

---
 rtl/display_scan_mux_if.sv | 27 ++
 rtl/display_scan_mux.sv | 110 +++++++++++
 tb/tb_display_scan_mux.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_mux_if.sv
// Bundle between a display controller and the scan multiplexer: frame inputs plus registered scan outputs.
interface display_scan_mux_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  enable;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic [3:0]            nibble;
    logic [DIGITS-1:0]     an;
    logic                  dp;
    logic [IDX_W-1:0]      digit_idx;

    // Controller side: drives the value to show, observes the scan
    modport master (
        output enable, value, dp_in, blank_lz,
        input  nibble, an, dp, digit_idx
    );

    // Scan multiplexer side
    modport slave (
        input  enable, value, dp_in, blank_lz,
        output nibble, an, dp, digit_idx
    );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed scan driver for a common-anode multi-digit 7-segment display.
// Snapshots value/dp_in once per frame so a frame never tears.
module display_scan_mux #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_mux_if.slave    bus
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    // ST_LOAD: no snapshot taken yet since reset, so outputs stay dark
    typedef enum logic {ST_LOAD, ST_SCAN} state_t;

    state_t                   state, state_nx;
    logic [DIV_W-1:0]         div_cnt, div_cnt_nx;
    logic [IDX_W-1:0]         idx, idx_nx;
    logic [DIGITS-1:0][3:0]   shadow_value, shadow_value_nx;
    logic [DIGITS-1:0]        shadow_dp, shadow_dp_nx;
    logic [3:0]               nibble, nibble_nx;
    logic [DIGITS-1:0]        an, an_nx;
    logic                     dp, dp_nx;

    logic [DIGITS-1:0]        blank_c;
    logic                     zero_run_c;
    logic                     div_tc_c;
    logic                     wrap_c;

    assign div_tc_c = (div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign wrap_c   = div_tc_c && (idx == IDX_W'(DIGITS - 1));

    // Leading-zero mask: digit i blanks when every shadow nibble from the top down to i is zero
    always_comb begin
        blank_c    = '0;
        zero_run_c = bus.blank_lz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run_c = zero_run_c && (shadow_value[i] == 4'h0);
            blank_c[i] = zero_run_c;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx        = state;
        div_cnt_nx      = div_cnt;
        idx_nx          = idx;
        shadow_value_nx = shadow_value;
        shadow_dp_nx    = shadow_dp;
        nibble_nx       = nibble;
        an_nx           = '1;
        dp_nx           = 1'b1;

        if (bus.enable) begin
            if (state == ST_LOAD) begin
                shadow_value_nx = bus.value;
                shadow_dp_nx    = bus.dp_in;
                state_nx        = ST_SCAN;
            end else begin
                nibble_nx = shadow_value[idx];
                if (!blank_c[idx]) begin
                    an_nx = ~(DIGITS'(1) << idx);
                    dp_nx = ~shadow_dp[idx];
                end
            end

            if (div_tc_c) begin
                div_cnt_nx = '0;
                if (wrap_c) begin
                    idx_nx          = '0;
                    shadow_value_nx = bus.value;
                    shadow_dp_nx    = bus.dp_in;
                end else begin
                    idx_nx = idx + IDX_W'(1);
                end
            end else begin
                div_cnt_nx = div_cnt + DIV_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_LOAD;
            div_cnt      <= '0;
            idx          <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            nibble       <= '0;
            an           <= '1;
            dp           <= 1'b1;
        end else begin
            state        <= state_nx;
            div_cnt      <= div_cnt_nx;
            idx          <= idx_nx;
            shadow_value <= shadow_value_nx;
            shadow_dp    <= shadow_dp_nx;
            nibble       <= nibble_nx;
            an           <= an_nx;
            dp           <= dp_nx;
        end
    end

    assign bus.nibble    = nibble;
    assign bus.an        = an;
    assign bus.dp        = dp;
    assign bus.digit_idx = idx;
endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed phases from the test plan plus random traffic,
// checked by a frame/slot reference model through an expectation queue.
module tb_display_scan_mux;
    localparam int unsigned D  = 4;
    localparam int unsigned RD = 4;

    typedef struct packed {
        logic [3:0]   nibble;
        logic [D-1:0] an;
        logic         dp;
        logic [1:0]   idx;
    } exp_t;

    logic clk;
    logic rst;
    display_scan_mux_if #(.DIGITS(D)) bus ();

    display_scan_mux #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   cycle;
    bit   done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts enabled edges since reset; slot and frame follow by division
    initial begin
        int          n;
        logic [15:0] snap_v;
        logic [3:0]  snap_dp;
        logic [3:0]  last_nib;
        int          d;
        exp_t        e;
        n = 0; snap_v = '0; snap_dp = '0; last_nib = '0;
        forever begin
            @(posedge clk);
            e.nibble = last_nib;
            e.an     = '1;
            e.dp     = 1'b1;
            if (rst) begin
                n = 0; snap_v = '0; snap_dp = '0;
                e.nibble = '0;
            end else if (bus.enable) begin
                if (n > 0) begin
                    d = (n / RD) % D;
                    e.nibble = 4'((snap_v >> (4 * d)) & 16'hF);
                    if (!(bus.blank_lz && d > 0 && (snap_v >> (4 * d)) == 16'h0)) begin
                        e.an = ~(4'b0001 << d);
                        e.dp = ~snap_dp[d];
                    end
                end
                if (n == 0 || ((n + 1) % (RD * D)) == 0) begin
                    snap_v  = bus.value;
                    snap_dp = bus.dp_in;
                end
                n = n + 1;
            end
            e.idx    = 2'((n / RD) % D);
            last_nib = e.nibble;
            exp_q.push_back(e);
        end
    end

    // Monitor: one registered output set per cycle, compared against the oldest expectation
    initial begin
        exp_t e;
        cycle = 0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL queue_empty cycle=%0d got=none required=entry", cycle);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.nibble !== e.nibble) begin
                    n_fail++;
                    $display("FAIL nibble cycle=%0d got=%h required=%h", cycle, bus.nibble, e.nibble);
                end
                n_checks++;
                if (bus.an !== e.an) begin
                    n_fail++;
                    $display("FAIL an cycle=%0d got=%b required=%b", cycle, bus.an, e.an);
                end
                n_checks++;
                if (bus.dp !== e.dp) begin
                    n_fail++;
                    $display("FAIL dp cycle=%0d got=%b required=%b", cycle, bus.dp, e.dp);
                end
                n_checks++;
                if (bus.digit_idx !== e.idx) begin
                    n_fail++;
                    $display("FAIL digit_idx cycle=%0d got=%0d required=%0d", cycle, bus.digit_idx, e.idx);
                end
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        logic [15:0] mask;
        n_checks = 0; n_fail = 0; done = 1'b0;
        rst = 1'b1;
        bus.enable = 1'b0; bus.value = 16'h1234; bus.dp_in = '0; bus.blank_lz = 1'b0;
        cyc(3);
        // Plain scan of 1234
        rst = 1'b0; bus.enable = 1'b1;
        cyc(20);
        // Leading-zero blanking on and off
        bus.value = 16'h00A5; bus.blank_lz = 1'b1;
        cyc(34);
        bus.blank_lz = 1'b0;
        cyc(16);
        // All zero: only digit 0 lights
        bus.value = 16'h0000; bus.blank_lz = 1'b1;
        cyc(34);
        // Fresh start with 1234, then change value mid-frame
        bus.blank_lz = 1'b0; bus.value = 16'h1234;
        rst = 1'b1; cyc(1); rst = 1'b0;
        cyc(6);
        bus.value = 16'hFFFF;
        cyc(24);
        // Decimal point on digit 2, deferred change, enable drop during digit 2
        bus.dp_in = 4'b0100;
        cyc(17);
        bus.dp_in = 4'b0001;
        cyc(10);
        bus.enable = 1'b0;
        cyc(10);
        bus.enable = 1'b1;
        cyc(20);
        // Reset mid-frame while enabled
        rst = 1'b1; cyc(1); rst = 1'b0;
        cyc(20);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
                bus.value = 16'($urandom) & mask;
            end
            if ($urandom_range(0, 7) == 0)  bus.dp_in    = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
            bus.enable = ($urandom_range(0, 9) != 0);
            rst        = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        rst = 1'b0; bus.enable = 1'b1;
        cyc(3);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the stimulus never finishes
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout cycle=%0d got=running required=finished", cycle);
            $fatal(1, "timeout");
        end
    end
endmodule
